// File: rtl/mult_share_arbiter.sv
// Two-port round-robin arbiter that time-shares one external combinational multiplier.
// Operands are captured at grant and the product is latched after CALC_CYCLES cycles.
module mult_share_arbiter #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned CALC_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic               ack0,
  output logic               ack1,
  output logic               done0,
  output logic               done1,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_p
);

  localparam logic [3:0] CntInit = 4'(CALC_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StCompute, StDone} state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic               owner_q, owner_d;
  logic               last_q, last_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               ack0_q, ack0_d, ack1_q, ack1_d;
  logic               done0_q, done0_d, done1_q, done1_d;
  logic               winner;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    owner_d   = owner_q;
    last_d    = last_q;
    product_d = product_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    winner    = 1'b0;
    case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          // On a tie the port that was not served last wins.
          winner  = (req0 && req1) ? ~last_q : req1;
          op_a_d  = winner ? a1 : a0;
          op_b_d  = winner ? b1 : b0;
          owner_d = winner;
          last_d  = winner;
          cnt_d   = CntInit;
          ack0_d  = ~winner;
          ack1_d  = winner;
          state_d = StCompute;
        end
      end
      StCompute: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          product_d = mul_p;
          done0_d   = ~owner_q;
          done1_d   = owner_q;
          state_d   = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      product_q <= '0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      product_q <= product_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
    end
  end

  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign done0   = done0_q;
  assign done1   = done1_q;
  assign product = product_q;
  assign busy    = (state_q != StIdle);
  assign mul_a   = op_a_q;
  assign mul_b   = op_b_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter: directed scenarios plus a randomized run
// checked against a transaction-timing reference model.
module tb_mult_share_arbiter;

  localparam int W = 4;
  localparam int C = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           req0, req1;
  logic [W-1:0]   a0, b0, a1, b1;
  logic           ack0, ack1, done0, done1, busy;
  logic [2*W-1:0] product, mul_p;
  logic [W-1:0]   mul_a, mul_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Stand-in for the external combinational multiplier.
  assign mul_p = (2*W)'(mul_a) * (2*W)'(mul_b);

  mult_share_arbiter #(.WIDTH(W), .CALC_CYCLES(C)) dut (
    .clk(clk), .rst(rst), .req0(req0), .a0(a0), .b0(b0), .req1(req1), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1), .product(product),
    .busy(busy), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req0 = 1'b0; req1 = 1'b0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({ack0, ack1, done0, done1, busy, product, mul_a, mul_b} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got ack=%b%b done=%b%b busy=%b p=%0d ma=%0d mb=%0d want all 0",
               ack0, ack1, done0, done1, busy, product, mul_a, mul_b);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [4:0] exp [4];
    exp = '{5'b10001, 5'b00001, 5'b00101, 5'b00000};
    req0 = 1'b1; a0 = 4'd7; b0 = 4'd9;
    for (int i = 0; i < 4; i++) begin
      tick();
      req0 = 1'b0;
      checks++;
      if ({ack0, ack1, done0, done1, busy} !== exp[i]) begin
        errors++;
        $display("FAIL single_c%0d ack/done/busy got %b want %b", i + 1,
                 {ack0, ack1, done0, done1, busy}, exp[i]);
      end
      if (i == 2) begin
        checks++;
        if (product !== 8'd63) begin
          errors++;
          $display("FAIL single_product got %0d want 63", product);
        end
      end
    end
  endtask

  task automatic test_tie();
    logic [4:0] exp [8];
    exp = '{5'b10001, 5'b00001, 5'b00101, 5'b00000,
            5'b01001, 5'b00001, 5'b00011, 5'b00000};
    apply_reset();
    req0 = 1'b1; a0 = 4'd15; b0 = 4'd15;
    req1 = 1'b1; a1 = 4'd3;  b1 = 4'd5;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ack0) req0 = 1'b0;
      if (ack1) req1 = 1'b0;
      checks++;
      if ({ack0, ack1, done0, done1, busy} !== exp[i]) begin
        errors++;
        $display("FAIL tie_c%0d ack/done/busy got %b want %b", i + 1,
                 {ack0, ack1, done0, done1, busy}, exp[i]);
      end
      if (i == 2 || i == 6) begin
        checks++;
        if (product !== ((i == 2) ? 8'd225 : 8'd15)) begin
          errors++;
          $display("FAIL tie_product_c%0d got %0d want %0d", i + 1, product,
                   (i == 2) ? 225 : 15);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic e0, e1, eb;
    apply_reset();
    req0 = 1'b1; a0 = 4'd2; b0 = 4'd2;
    req1 = 1'b1; a1 = 4'd3; b1 = 4'd3;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 12) begin req0 = 1'b0; req1 = 1'b0; end
      e0 = (i == 1) || (i == 9);
      e1 = (i == 5);
      eb = (i % 4) != 0;
      checks++;
      if ({ack0, ack1, busy} !== {e0, e1, eb}) begin
        errors++;
        $display("FAIL b2b_c%0d ack0/ack1/busy got %b want %b", i, {ack0, ack1, busy},
                 {e0, e1, eb});
      end
    end
  endtask

  task automatic test_operand_change();
    apply_reset();
    req1 = 1'b1; a1 = 4'd6; b1 = 4'd7;
    tick();
    checks++;
    if (ack1 !== 1'b1) begin
      errors++;
      $display("FAIL opchg_ack1 got %b want 1", ack1);
    end
    req1 = 1'b0; a1 = 4'd15; b1 = 4'd15;
    tick();
    checks++;
    if ({mul_a, mul_b} !== {4'd6, 4'd7}) begin
      errors++;
      $display("FAIL opchg_mul_ops got %0d,%0d want 6,7", mul_a, mul_b);
    end
    tick();
    checks++;
    if ({done1, product} !== {1'b1, 8'd42}) begin
      errors++;
      $display("FAIL opchg_result got done1=%b p=%0d want done1=1 p=42", done1, product);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    req0 = 1'b1; a0 = 4'd5; b0 = 4'd5;
    tick();
    req0 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({ack0, ack1, done0, done1, busy, product, mul_a, mul_b} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs got ack=%b%b done=%b%b busy=%b p=%0d want all 0",
               ack0, ack1, done0, done1, busy, product);
    end
    tick();
    tick();
    checks++;
    if ({done0, done1, busy} !== 3'b000) begin
      errors++;
      $display("FAIL rstmid_no_done got done=%b%b busy=%b want 000", done0, done1, busy);
    end
    req0 = 1'b1; a0 = 4'd2; b0 = 4'd8;
    tick();
    req0 = 1'b0;
    tick();
    tick();
    checks++;
    if ({done0, product} !== {1'b1, 8'd16}) begin
      errors++;
      $display("FAIL rstmid_after got done0=%b p=%0d want done0=1 p=16", done0, product);
    end
    tick();
  endtask

  task automatic test_zero_operand();
    req0 = 1'b1; a0 = 4'd0; b0 = 4'd13;
    tick();
    req0 = 1'b0;
    tick();
    tick();
    checks++;
    if ({done0, product} !== {1'b1, 8'd0}) begin
      errors++;
      $display("FAIL zero_result got done0=%b p=%0d want done0=1 p=0", done0, product);
    end
    tick();
  endtask

  // Reference model works in edge indices: a grant at edge k is acked after edge k,
  // completes after edge k+C, and the next grant may happen at edge k+C+2.
  task automatic test_random();
    int next_grant, ack_edge, done_edge;
    logic last, win, r0, r1;
    logic [2*W-1:0] pend, exp_prod;
    logic [W-1:0] ea, eb;
    logic e_a0, e_a1, e_d0, e_d1, e_busy;
    apply_reset();
    next_grant = 0; ack_edge = -100; done_edge = -100;
    last = 1'b1; win = 1'b0; pend = '0; exp_prod = '0; ea = '0; eb = '0;
    for (int k = 0; k < 400; k++) begin
      r0 = ($urandom_range(0, 2) == 0);
      r1 = ($urandom_range(0, 2) == 0);
      req0 = r0; req1 = r1;
      a0 = W'($urandom); b0 = W'($urandom);
      a1 = W'($urandom); b1 = W'($urandom);
      if (k >= next_grant && (r0 || r1)) begin
        win = (r0 && r1) ? (last == 1'b1 ? 1'b0 : 1'b1) : r1;
        last = win;
        ea = win ? a1 : a0;
        eb = win ? b1 : b0;
        pend = 8'(int'(ea) * int'(eb));
        ack_edge = k; done_edge = k + C; next_grant = k + C + 2;
      end
      if (k == done_edge) exp_prod = pend;
      tick();
      e_a0 = (k == ack_edge) && !win;
      e_a1 = (k == ack_edge) && win;
      e_d0 = (k == done_edge) && !win;
      e_d1 = (k == done_edge) && win;
      e_busy = (k >= ack_edge) && (k <= done_edge);
      checks++;
      if ({ack0, ack1, done0, done1, busy, product, mul_a, mul_b} !==
          {e_a0, e_a1, e_d0, e_d1, e_busy, exp_prod, ea, eb}) begin
        errors++;
        $display("FAIL rand_k%0d got ack=%b%b done=%b%b busy=%b p=%0d ma=%0d mb=%0d want ack=%b%b done=%b%b busy=%b p=%0d ma=%0d mb=%0d",
                 k, ack0, ack1, done0, done1, busy, product, mul_a, mul_b,
                 e_a0, e_a1, e_d0, e_d1, e_busy, exp_prod, ea, eb);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_back_to_back();
    test_operand_change();
    test_reset_mid();
    test_zero_operand();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_share_arbiter.md
MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

Interface
REQ-001 Parameter WIDTH, default 4: operand width of the shared multiplier.
REQ-002 Parameter CALC_CYCLES, default 2: cycles operands are held on the multiplier before the result is captured; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req0  input  1  port 0 request, level-sensitive.
REQ-006 a0, b0  input  WIDTH each  port 0 multiplicand and multiplier.
REQ-007 req1  input  1  port 1 request, level-sensitive.
REQ-008 a1, b1  input  WIDTH each  port 1 multiplicand and multiplier.
REQ-009 ack0, ack1  output  1 each  one-cycle pulse; operands of that port captured.
REQ-010 done0, done1  output  1 each  one-cycle pulse; product valid for that port.
REQ-011 product  output  2*WIDTH  registered result of last completed operation.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 mul_a, mul_b  output  WIDTH each  operands driven to the external combinational multiplier (multiplier_csa, same WIDTH).
REQ-014 mul_p  input  2*WIDTH  product returned by the external multiplier.

Function
REQ-015 FSM states: IDLE, COMPUTE, DONE; encoding is free.
REQ-016 IDLE, no request: remain in IDLE, no outputs change.
REQ-017 IDLE, at least one req high at a clock edge: select winner, load op_a/op_b from winner's operands, record owner, load cnt = CALC_CYCLES-1, assert ack of winner for the following cycle only, go to COMPUTE.
REQ-018 Arbitration is round-robin: single request wins; if both are high, the port not served last wins; the last-served register resets to port 1, so port 0 wins the first tie after reset.
REQ-019 COMPUTE: if cnt != 0, decrement cnt; if cnt == 0, capture mul_p into product, assert owner's done for the following cycle only, go to DONE.
REQ-020 DONE: deassert done, return to IDLE; no request is sampled in DONE.
REQ-021 Latency: done rises exactly CALC_CYCLES cycles after ack rises; earliest next ack is CALC_CYCLES+2 cycles after the previous ack.
REQ-022 Requests while busy are ignored (no ack, no operand capture); a req still high when IDLE is re-entered is treated as a new request.
REQ-023 Operands are captured at grant; requester may change a/b or drop req after ack without affecting the result.
REQ-024 mul_a = op_a, mul_b = op_b at all times (registered, stable for the whole COMPUTE window).
REQ-025 product holds its value between completions; it is never truncated (full 2*WIDTH bits).
REQ-026 ack0/ack1 never high together; done0/done1 never high together; done goes only to the port that was acked.
REQ-027 CALC_CYCLES = 1: capture happens on the first COMPUTE cycle (done one cycle after ack).

Reset
REQ-028 rst high at a clock edge forces: state IDLE, cnt 0, op_a/op_b 0, product 0, ack0/ack1/done0/done1 0, busy 0, last-served = port 1.
REQ-029 Reset mid-operation aborts it: no done is issued for the aborted operation and product reads 0.
REQ-030 rst has priority over every other input in the same cycle.

Verification (WIDTH=4, CALC_CYCLES=2)
REQ-031 Single: req0, a0=7, b0=9 -> ack0 one cycle, done0 two cycles later, product=63, busy high from ack through done cycle.
REQ-032 Tie after reset: req0 (15x15) and req1 (3x5) together, held until acked -> ack0 first, done0 with product=225; ack1 four cycles after ack0, done1 with product=15.
REQ-033 Both held continuously for 12 cycles -> acks alternate 0,1,0 at 4-cycle spacing; no ack while busy.
REQ-034 Operand change after ack: req1 a1=6,b1=7, then a1=b1=15 the cycle after ack1 -> product=42.
REQ-035 rst pulse in the COMPUTE state -> no done, all outputs 0 next cycle; subsequent req0 2x8 -> product=16.
REQ-036 Zero operand: req0 a0=0, b0=13 -> done0 with product=0.
